pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and clear pins of the PC register and the four falling-edge pipeline latches (F/D, D/X, X/M, M/W).
- Handles three cases: load-use bubbles, taken-branch flushes, and multi-cycle multdiv waits with a timeout.
- Sits beside the decode hazard detector and the multdiv unit. Its state register updates on the rising edge of clk. Its outputs settle before the falling edge at which the latches capture.

---
 rtl/pipe_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes and multdiv waits with a timeout release.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lu_hazard,
  input  logic             br_taken,
  input  logic             md_start,
  input  logic             md_ready,
  input  logic             md_exc,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             fd_clr,
  output logic             dx_clr,
  output logic             xm_clr,
  output logic             mw_clr,
  output logic             md_go,
  output logic             md_timeout,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             busy
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MD_TIMEOUT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_md_timeout;
  logic             w_timeout_nxt;
  logic             w_hit_last;

  assign w_hit_last = (r_wait_cnt == CNT_LAST);

  always_comb begin
    pc_en         = 1'b1;
    fd_en         = 1'b1;
    dx_en         = 1'b1;
    xm_en         = 1'b1;
    mw_en         = 1'b1;
    fd_clr        = 1'b0;
    dx_clr        = 1'b0;
    xm_clr        = 1'b0;
    mw_clr        = 1'b0;
    md_go         = 1'b0;
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_wait_cnt;
    w_timeout_nxt = r_md_timeout;

    if (reset) begin
      {pc_en, fd_en, dx_en, xm_en, mw_en} = '0;
      {fd_clr, dx_clr, xm_clr, mw_clr}    = '1;
    end else begin
      unique case (r_state)
        RUN: begin
          if (md_start) begin
            md_go       = 1'b1;
            pc_en       = 1'b0;
            fd_en       = 1'b0;
            dx_en       = 1'b0;
            xm_clr      = 1'b1;
            w_state_nxt = MD_WAIT;
            w_cnt_nxt   = '0;
          end else if (br_taken) begin
            fd_clr = 1'b1;
            dx_clr = 1'b1;
          end else if (lu_hazard) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_clr = 1'b1;
          end
        end
        MD_WAIT: begin
          // EX is frozen here, so branch/load-use/start inputs are not looked at
          if (md_ready || md_exc || w_hit_last) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
            if (!md_ready && !md_exc)
              w_timeout_nxt = 1'b1;
          end else begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_en  = 1'b0;
            xm_clr = 1'b1;
            if (r_wait_cnt != CNT_SAT)
              w_cnt_nxt = r_wait_cnt + 1'b1;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_wait_cnt   <= '0;
      r_md_timeout <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_cnt_nxt;
      r_md_timeout <= w_timeout_nxt;
    end
  end

  assign md_timeout = r_md_timeout;
  assign wait_cnt   = r_wait_cnt;
  assign busy       = (r_state == MD_WAIT);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, load-use, branch, multdiv release paths.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset, lu_hazard, br_taken, md_start, md_ready, md_exc;
  logic       pc_en, fd_en, dx_en, xm_en, mw_en;
  logic       fd_clr, dx_clr, xm_clr, mw_clr;
  logic       md_go, md_timeout, busy;
  logic [5:0] wait_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned go_cnt;

  pipe_hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .lu_hazard(lu_hazard), .br_taken(br_taken),
    .md_start(md_start), .md_ready(md_ready), .md_exc(md_exc),
    .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
    .fd_clr(fd_clr), .dx_clr(dx_clr), .xm_clr(xm_clr), .mw_clr(mw_clr),
    .md_go(md_go), .md_timeout(md_timeout), .wait_cnt(wait_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] EN_ALL = 5'b11111, EN_NONE = 5'b00000;
  localparam logic [4:0] EN_LU  = 5'b00111, EN_MD   = 5'b00011;
  localparam logic [3:0] CL_NONE = 4'b0000, CL_ALL = 4'b1111;
  localparam logic [3:0] CL_BR   = 4'b1100, CL_LU  = 4'b0100, CL_MD = 4'b0010;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Combined output check; called with inputs already settled.
  task automatic chk_out(input string tag, input logic [4:0] en, input logic [3:0] cl,
                         input logic go, input logic bz);
    chk({tag, ".en"},   32'({pc_en, fd_en, dx_en, xm_en, mw_en}), 32'(en));
    chk({tag, ".clr"},  32'({fd_clr, dx_clr, xm_clr, mw_clr}), 32'(cl));
    chk({tag, ".go"},   32'(md_go), 32'(go));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
  endtask

  task automatic next_cyc;
    if (md_go) go_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic lu, input logic br,
                        input logic ms, input logic mr, input logic me);
    reset = r; lu_hazard = lu; br_taken = br; md_start = ms; md_ready = mr; md_exc = me;
    #1;
  endtask

  initial begin
    go_cnt = 0;
    set_in(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      chk_out("reset", EN_NONE, CL_ALL, 1'b0, 1'b0);
      next_cyc();
    end
    set_in(0, 0, 0, 0, 0, 0);
    chk_out("idle", EN_ALL, CL_NONE, 1'b0, 1'b0);
    chk("idle.cnt", 32'(wait_cnt), 32'd0);
    chk("idle.to", 32'(md_timeout), 32'd0);

    // single load-use bubble
    next_cyc(); set_in(0, 1, 0, 0, 0, 0);
    chk_out("lu1", EN_LU, CL_LU, 1'b0, 1'b0);
    next_cyc(); set_in(0, 0, 0, 0, 0, 0);
    chk_out("lu1.after", EN_ALL, CL_NONE, 1'b0, 1'b0);
    // back-to-back two bubbles
    next_cyc(); set_in(0, 1, 0, 0, 0, 0);
    chk_out("lu2a", EN_LU, CL_LU, 1'b0, 1'b0);
    next_cyc();
    chk_out("lu2b", EN_LU, CL_LU, 1'b0, 1'b0);
    next_cyc(); set_in(0, 0, 0, 0, 0, 0);
    chk_out("lu2.after", EN_ALL, CL_NONE, 1'b0, 1'b0);

    // branch wins over load-use
    next_cyc(); set_in(0, 1, 1, 0, 0, 0);
    chk_out("br_lu", EN_ALL, CL_BR, 1'b0, 1'b0);
    next_cyc(); set_in(0, 0, 0, 0, 0, 0);
    chk_out("br.after", EN_ALL, CL_NONE, 1'b0, 1'b0);

    // multdiv with md_ready 17 cycles after start; start wins over branch
    go_cnt = 0;
    next_cyc(); set_in(0, 1, 1, 1, 0, 0);
    chk_out("md.start", EN_MD, CL_MD, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      next_cyc();
      chk_out("md.wait", EN_MD, CL_MD, 1'b0, 1'b1);
      chk("md.wait.cnt", 32'(wait_cnt), 32'(k - 1));
    end
    next_cyc(); set_in(0, 0, 0, 1, 1, 0);
    chk_out("md.rel", EN_ALL, CL_NONE, 1'b0, 1'b1);
    chk("md.rel.cnt", 32'(wait_cnt), 32'd16);
    next_cyc(); set_in(0, 0, 0, 0, 0, 0);
    chk_out("md.run", EN_ALL, CL_NONE, 1'b0, 1'b0);
    chk("md.run.cnt", 32'(wait_cnt), 32'd0);
    chk("md.run.to", 32'(md_timeout), 32'd0);
    chk("md.go_pulses", 32'(go_cnt), 32'd1);

    // release by md_exc together with md_ready after 3 wait cycles
    next_cyc(); set_in(0, 0, 0, 1, 0, 0);
    chk_out("exc.start", EN_MD, CL_MD, 1'b1, 1'b0);
    next_cyc(); set_in(0, 0, 0, 0, 0, 0);
    next_cyc();
    next_cyc(); set_in(0, 0, 0, 0, 1, 1);
    chk_out("exc.rel", EN_ALL, CL_NONE, 1'b0, 1'b1);
    chk("exc.rel.cnt", 32'(wait_cnt), 32'd2);
    next_cyc(); set_in(0, 0, 0, 0, 0, 0);
    chk("exc.busy", 32'(busy), 32'd0);
    chk("exc.to", 32'(md_timeout), 32'd0);

    // timeout: 40 wait cycles, release at wait_cnt 39
    next_cyc(); set_in(0, 0, 0, 1, 0, 0);
    chk_out("to.start", EN_MD, CL_MD, 1'b1, 1'b0);
    next_cyc(); set_in(0, 0, 0, 0, 0, 0);
    for (int k = 1; k < 40; k++) begin
      chk_out("to.wait", EN_MD, CL_MD, 1'b0, 1'b1);
      chk("to.wait.cnt", 32'(wait_cnt), 32'(k - 1));
      next_cyc();
    end
    chk_out("to.rel", EN_ALL, CL_NONE, 1'b0, 1'b1);
    chk("to.rel.cnt", 32'(wait_cnt), 32'd39);
    chk("to.rel.flag", 32'(md_timeout), 32'd0);
    next_cyc();
    chk("to.flag", 32'(md_timeout), 32'd1);
    chk("to.busy", 32'(busy), 32'd0);
    chk("to.cnt", 32'(wait_cnt), 32'd0);
    set_in(0, 0, 0, 0, 1, 0);
    next_cyc(); set_in(0, 0, 0, 0, 0, 0);
    next_cyc();
    chk("to.sticky", 32'(md_timeout), 32'd1);
    set_in(1, 0, 0, 0, 0, 0);
    next_cyc(); set_in(0, 0, 0, 0, 0, 0);
    chk("to.cleared", 32'(md_timeout), 32'd0);

    // reset during MD_WAIT cycle 5
    next_cyc(); set_in(0, 0, 0, 1, 0, 0);
    next_cyc(); set_in(0, 0, 0, 0, 0, 0);
    for (int k = 1; k < 5; k++) next_cyc();
    chk("rw.cnt5", 32'(wait_cnt), 32'd4);
    set_in(1, 0, 0, 0, 0, 0);
    chk_out("rw.reset", EN_NONE, CL_ALL, 1'b0, 1'b1);
    next_cyc(); set_in(0, 0, 0, 0, 0, 0);
    chk_out("rw.run", EN_ALL, CL_NONE, 1'b0, 1'b0);
    chk("rw.cnt", 32'(wait_cnt), 32'd0);
    next_cyc(); set_in(0, 0, 0, 0, 1, 0);
    chk_out("rw.stray_ready", EN_ALL, CL_NONE, 1'b0, 1'b0);
    next_cyc(); set_in(0, 0, 0, 0, 0, 0);
    chk("rw.busy", 32'(busy), 32'd0);
    chk("rw.to", 32'(md_timeout), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
